dcache_ctrl: RTL

//  Direct-mapped, write-back, write-allocate data cache between the core LSU and the memory block.
//  - Serves 32-bit word loads and stores.
//  - On a miss, fetches or evicts whole 128-bit lines through the memory's address-hold handshake.

---
 rtl/dcache_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache between the core LSU
// and the line-wide memory block. Word loads/stores; whole lines move to and from memory
// through the memory's address-hold handshake.
// Optional feature: define DCACHE_STATS_EN to add the stat_hits/stat_misses/stat_wbs counters.
module dcache_ctrl #(
  parameter int unsigned          ARCH_BITS  = 32,
  parameter int unsigned          LINE_BITS  = 128,
  parameter int unsigned          NUM_LINES  = 16,
  parameter int unsigned          INDEX_BITS = 4,
  parameter logic [ARCH_BITS-1:0] PARK_ADDR  = 32'hFFFF_FFF0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ARCH_BITS-1:0] req_addr,
  input  logic [ARCH_BITS-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [ARCH_BITS-1:0] resp_rdata,
  output logic [ARCH_BITS-1:0] mem_rAddr,
  input  logic [LINE_BITS-1:0] mem_rData,
  input  logic                 mem_rValid,
  output logic [ARCH_BITS-1:0] mem_wAddr,
  output logic [LINE_BITS-1:0] mem_wData,
  output logic                 mem_WE,
  input  logic                 mem_wDone
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          stat_hits,
  output logic [31:0]          stat_misses,
  output logic [31:0]          stat_wbs
`endif
);

  localparam int unsigned WordsPerLine = LINE_BITS / ARCH_BITS;
  localparam int unsigned OffBits      = $clog2(LINE_BITS / 8);
  localparam int unsigned SelBits      = $clog2(WordsPerLine);
  localparam int unsigned TagBits      = ARCH_BITS - OffBits - INDEX_BITS;

  typedef enum logic [1:0] {StIdle, StCompare, StWb, StFill} state_e;

  state_e stateQ, stateD;

  logic [ARCH_BITS-1:0] addrQ, wdataQ;
  logic                 weQ;
  logic [NUM_LINES-1:0] validQ, dirtyQ;
  logic                 fillFirstQ;
  logic                 respValidQ;
  logic [ARCH_BITS-1:0] respRdataQ;

  logic [TagBits-1:0]   tagArr  [NUM_LINES];
  logic [LINE_BITS-1:0] dataArr [NUM_LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TagBits-1:0]    reqTag;
  logic [SelBits-1:0]    wordSel;
  logic [LINE_BITS-1:0]  curLine, mergedLine;
  logic                  hit, accept;
  logic                  storeHit, fillDone, wbDone;
  logic                  respValidD;
  logic [ARCH_BITS-1:0]  respRdataD;
  logic [1:0]            unusedAddrBits;

  // Byte offset inside a word carries no meaning for word accesses.
  assign unusedAddrBits = addrQ[1:0];

  assign idx     = addrQ[OffBits +: INDEX_BITS];
  assign reqTag  = addrQ[ARCH_BITS-1 -: TagBits];
  assign wordSel = addrQ[OffBits-1:2];
  assign curLine = dataArr[idx];
  assign hit     = validQ[idx] && (tagArr[idx] == reqTag);

  // Ready is withheld during the response cycle so the next accept lands one cycle later.
  assign req_ready  = (stateQ == StIdle) && !respValidQ;
  assign accept     = req_valid && req_ready;
  assign resp_valid = respValidQ;
  assign resp_rdata = respRdataQ;

  // Store data merged into the resident line
  always_comb begin
    mergedLine = curLine;
    mergedLine[wordSel*ARCH_BITS +: ARCH_BITS] = wdataQ;
  end

  // Next-state logic, memory-side outputs and datapath strobes
  always_comb begin
    stateD     = stateQ;
    storeHit   = 1'b0;
    fillDone   = 1'b0;
    wbDone     = 1'b0;
    respValidD = 1'b0;
    respRdataD = '0;
    mem_rAddr  = PARK_ADDR;
    mem_wAddr  = PARK_ADDR;
    mem_wData  = '0;
    mem_WE     = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (accept) stateD = StCompare;
      end
      StCompare: begin
        if (hit) begin
          respValidD = 1'b1;
          if (weQ) storeHit = 1'b1;
          else     respRdataD = curLine[wordSel*ARCH_BITS +: ARCH_BITS];
          stateD = StIdle;
        end else if (validQ[idx] && dirtyQ[idx]) begin
          stateD = StWb;
        end else begin
          stateD = StFill;
        end
      end
      StWb: begin
        // Victim address and data are stable: nothing they depend on changes in this state.
        mem_wAddr = {tagArr[idx], idx, {OffBits{1'b0}}};
        mem_wData = curLine;
        mem_WE    = 1'b1;
        if (mem_wDone) begin
          wbDone = 1'b1;
          stateD = StFill;
        end
      end
      StFill: begin
        mem_rAddr = {reqTag, idx, {OffBits{1'b0}}};
        // rValid in the first cycle may be stale from before the address changed.
        if (mem_rValid && !fillFirstQ) begin
          fillDone = 1'b1;
          stateD   = StCompare;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) stateQ <= StIdle;
    else     stateQ <= stateD;
  end

  // Request capture, valid/dirty bookkeeping and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      addrQ      <= '0;
      weQ        <= 1'b0;
      wdataQ     <= '0;
      validQ     <= '0;
      dirtyQ     <= '0;
      fillFirstQ <= 1'b0;
      respValidQ <= 1'b0;
      respRdataQ <= '0;
    end else begin
      if (accept) begin
        addrQ  <= req_addr;
        weQ    <= req_we;
        wdataQ <= req_wdata;
      end
      fillFirstQ <= (stateD == StFill) && (stateQ != StFill);
      respValidQ <= respValidD;
      respRdataQ <= respRdataD;
      if (storeHit) dirtyQ[idx] <= 1'b1;
      if (wbDone)   dirtyQ[idx] <= 1'b0;
      if (fillDone) begin
        validQ[idx] <= 1'b1;
        dirtyQ[idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays; contents are meaningless until the matching valid bit is set
  always_ff @(posedge clk) begin
    if (fillDone) begin
      dataArr[idx] <= mem_rData;
      tagArr[idx]  <= reqTag;
    end else if (storeHit) begin
      dataArr[idx] <= mergedLine;
    end
  end

`ifdef DCACHE_STATS_EN
  logic fromFillQ;

  // Each request counts once as hit or miss at its first COMPARE; the re-check after a fill
  // is not counted again
  always_ff @(posedge clk) begin
    if (rst) begin
      fromFillQ   <= 1'b0;
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wbs    <= '0;
    end else begin
      fromFillQ <= (stateQ == StFill) && (stateD == StCompare);
      if ((stateQ == StCompare) && !fromFillQ) begin
        if (hit) stat_hits   <= stat_hits + 32'd1;
        else     stat_misses <= stat_misses + 32'd1;
      end
      if (wbDone) stat_wbs <= stat_wbs + 32'd1;
    end
  end
`endif

endmodule
